// File: rtl/step_pkg.sv
// Shared definitions for the step phase sequencer: index width, mode encodings
// and the eight-entry half-step coil table.
package step_pkg;

  localparam int IDX_W = 3;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    STEP_HALF = 1'b0,
    STEP_FULL = 1'b1
  } step_mode_e;

  typedef enum logic {
    DIR_REV = 1'b0,
    DIR_FWD = 1'b1
  } step_dir_e;

  // Coil pattern {A, B, A_n, B_n}; odd indices are the two-phase-on entries.
  function automatic logic [3:0] phase_coils(input idx_t idx);
    logic [3:0] pat;
    case (idx)
      3'd0:    pat = 4'b1000;
      3'd1:    pat = 4'b1100;
      3'd2:    pat = 4'b0100;
      3'd3:    pat = 4'b0110;
      3'd4:    pat = 4'b0010;
      3'd5:    pat = 4'b0011;
      3'd6:    pat = 4'b0001;
      3'd7:    pat = 4'b1001;
      default: pat = 4'b0000;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/step_tick_gen.sv
// Step-rate prescaler: one tick every DIV cycles of continuous en, with the
// first tick DIV cycles after en is first sampled high.
module step_tick_gen #(
  parameter logic [15:0] DIV = 16'd1000
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  logic [15:0] cnt_q, cnt_d;
  logic        en_q;

  // en_q gates the rising-edge cycle so the count restarts from zero there.
  assign tick = en && en_q && (cnt_q == (DIV - 16'd1));

  // Next prescaler count.
  always_comb begin
    cnt_d = cnt_q;
    if (!en || !en_q) begin
      cnt_d = 16'd0;
    end else if (tick) begin
      cnt_d = 16'd0;
    end else begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  // Prescaler and enable-history registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= 16'd0;
      en_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      en_q  <= en;
    end
  end

endmodule

// File: rtl/step_phase_seq.sv
// Stepper phase sequencer: walks the half/full-step coil table on each tick.
// Build option STEP_HOLD_EN keeps the last pattern energized while idle.
module step_phase_seq
  import step_pkg::*;
#(
  parameter logic [15:0] DIV = 16'd1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  input  logic       dir,
  input  logic       run,
  output logic [3:0] coils,
  output logic       busy,
  output logic [7:0] step_cnt
);

  idx_t       idx_q, idx_d;
  idx_t       mag_s;
  logic [3:0] coils_q, coils_d;
  logic [7:0] cnt_q, cnt_d;
  logic       run_q;
  logic       tick_s;
  logic       rise_s;
  logic       adv_s;

  step_tick_gen #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .tick (tick_s)
  );

  assign rise_s = run && !run_q;
  // A tick while run is low never moves the rotor.
  assign adv_s  = run && tick_s;

  // Phase index advance: full step from an even index first lands on odd.
  always_comb begin
    idx_d = idx_q;
    mag_s = 3'd1;
    if (adv_s) begin
      if ((step == STEP_FULL) && idx_q[0]) begin
        mag_s = 3'd2;
      end else begin
        mag_s = 3'd1;
      end
      if (dir == DIR_FWD) begin
        idx_d = idx_q + mag_s;
      end else begin
        idx_d = idx_q - mag_s;
      end
    end else begin
      idx_d = idx_q;
    end
  end

  // Coil pattern and saturating step counter.
  always_comb begin
    coils_d = coils_q;
    cnt_d   = cnt_q;
    if (run) begin
      coils_d = phase_coils(idx_d);
    end else begin
`ifdef STEP_HOLD_EN
      coils_d = coils_q;
`else
      coils_d = 4'b0000;
`endif
    end
    if (rise_s) begin
      cnt_d = 8'd0;
    end else if (adv_s && (cnt_q != 8'hFF)) begin
      cnt_d = cnt_q + 8'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      idx_q   <= 3'd0;
      coils_q <= 4'b0000;
      cnt_q   <= 8'd0;
      run_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      coils_q <= coils_d;
      cnt_q   <= cnt_d;
      run_q   <= run;
    end
  end

  assign coils    = coils_q;
  assign busy     = run_q;
  assign step_cnt = cnt_q;

endmodule

// File: tb/tb_step_phase_seq.sv
// Self-checking bench for step_phase_seq (DIV=4) against a behavioural model.
module tb_step_phase_seq;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst, step, dir, run;
  logic [3:0] coils;
  logic       busy;
  logic [7:0] step_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model state: age = consecutive cycles run has been sampled high.
  int         m_idx, m_age, m_cnt;
  logic [3:0] m_coils;
  logic       m_busy;
  logic [3:0] tbl [8];

  step_phase_seq #(.DIV(16'(DIV))) dut (
    .clk      (clk),
    .rst      (rst),
    .step     (step),
    .dir      (dir),
    .run      (run),
    .coils    (coils),
    .busy     (busy),
    .step_cnt (step_cnt)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_update();
    int amt;
    if (!rst) begin
      m_idx = 0; m_age = 0; m_cnt = 0; m_coils = 4'b0000; m_busy = 1'b0;
    end else begin
      m_busy = run;
      if (run) begin
        if (m_age == 0) begin
          m_cnt = 0;
        end else if (m_age % DIV == 0) begin
          amt = (step && (m_idx % 2 == 1)) ? 2 : 1;
          m_idx = (m_idx + (dir ? amt : 8 - amt)) % 8;
          if (m_cnt < 255) m_cnt++;
        end
        m_age++;
        m_coils = tbl[m_idx];
      end else begin
        m_age = 0;
`ifndef STEP_HOLD_EN
        m_coils = 4'b0000;
`endif
      end
    end
  endtask

  task automatic tick_clk();
    @(posedge clk);
    model_update();
    #1;
    check_eq("coils", coils, m_coils);
    check_eq("busy", busy, m_busy);
    check_eq("step_cnt", step_cnt, m_cnt);
  endtask

  initial begin
    logic [3:0] half_exp [6];
    logic [3:0] full_exp [5];
    logic [3:0] held;
    tbl = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011, 4'b0001, 4'b1001};
    half_exp = '{4'b1000, 4'b1100, 4'b0100, 4'b0110, 4'b0010, 4'b0011};
    full_exp = '{4'b1001, 4'b0011, 4'b0110, 4'b1100, 4'b1001};
    m_idx = 0; m_age = 0; m_cnt = 0; m_coils = 4'b0000; m_busy = 1'b0;

    // Reset with arbitrary run, then idle.
    rst = 1'b0; step = 1'b0; dir = 1'b1; run = 1'($urandom_range(0, 1));
    repeat (3) tick_clk();
    rst = 1'b1; run = 1'b0;
    repeat (2) tick_clk();
    check_eq("rst_coils", coils, 4'b0000);
    check_eq("rst_cnt", step_cnt, 8'd0);
    check_eq("rst_busy", busy, 1'b0);

    // Half step forward: ticks on cycles 4..20.
    step = 1'b0; dir = 1'b1; run = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      tick_clk();
      if (c % DIV == 0) check_eq("half_seq", coils, half_exp[c / DIV]);
    end
    check_eq("half_cnt", step_cnt, 8'd5);
    run = 1'b0;
    tick_clk();
`ifdef STEP_HOLD_EN
    check_eq("idle_coils", coils, 4'b0011);
`else
    check_eq("idle_coils", coils, 4'b0000);
`endif
    check_eq("idle_cnt", step_cnt, 8'd5);

    // Full step reverse from idx 0.
    rst = 1'b0;
    tick_clk();
    rst = 1'b1; step = 1'b1; dir = 1'b0; run = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      tick_clk();
      if (c > 0 && c % DIV == 0) check_eq("full_seq", coils, full_exp[c / DIV - 1]);
    end
    check_eq("full_cnt", step_cnt, 8'd5);

    // Run drops exactly on the next tick cycle.
    repeat (DIV - 1) tick_clk();
    held = coils;
    run = 1'b0;
    tick_clk();
`ifdef STEP_HOLD_EN
    check_eq("fall_tick", coils, held);
`else
    check_eq("fall_tick", coils, 4'b0000);
`endif
    run = 1'b1;
    tick_clk();
    check_eq("retain_idx", coils, 4'b1001);

    // Long run with random mode/direction: counter saturates.
    run = 1'b0;
    tick_clk();
    run = 1'b1;
    for (int c = 0; c < 1100 * DIV + 8; c++) begin
      step = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      tick_clk();
    end
    check_eq("sat_cnt", step_cnt, 8'd255);

    // Reset mid-run at step_cnt=3.
    rst = 1'b0; run = 1'b0;
    tick_clk();
    rst = 1'b1; step = 1'b0; dir = 1'b1; run = 1'b1;
    repeat (3 * DIV + 1) tick_clk();
    check_eq("pre_rst_cnt", step_cnt, 8'd3);
    rst = 1'b0;
    tick_clk();
    check_eq("mid_rst_coils", coils, 4'b0000);
    check_eq("mid_rst_cnt", step_cnt, 8'd0);
    check_eq("mid_rst_busy", busy, 1'b0);
    rst = 1'b1;
    repeat (DIV) tick_clk();
    check_eq("restart_hold", coils, 4'b1000);
    check_eq("restart_cnt0", step_cnt, 8'd0);
    tick_clk();
    check_eq("restart_tick", coils, 4'b1100);
    check_eq("restart_cnt1", step_cnt, 8'd1);

    // Random traffic including run toggles and occasional reset.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      step = 1'($urandom_range(0, 1));
      dir  = 1'($urandom_range(0, 1));
      rst  = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      tick_clk();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/step_phase_seq.md
STEP_PHASE_SEQ -- requirements
Module: step_phase_seq

Interface
REQ-001 SHALL have parameter DIV, default 16'd1000: clk cycles per step tick, legal range 2..65535.
REQ-002 SHALL have port clk  input  1: motor clock (clk_for_motor); all logic on its rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-low.
REQ-004 SHALL have port step  input  1: step mode; 1 = full step, 0 = half step.
REQ-005 SHALL have port dir  input  1: direction; 1 = forward (index +), 0 = reverse (index -).
REQ-006 SHALL have port run  input  1: level enable from the quarter-turn window; high = stepping allowed.
REQ-007 SHALL have port coils  output  4: coil drive pattern {A, B, A_n, B_n}, registered.
REQ-008 SHALL have port busy  output  1: high while run is sampled high and the block is stepping.
REQ-009 SHALL have port step_cnt  output  8: steps issued since the last run rising edge, registered.

Function
REQ-010 SHALL hold a 3-bit phase index; the half-step table is idx0..7 = 1000, 1100, 0100, 0110, 0010, 0011, 0001, 1001.
REQ-011 SHALL, in full-step mode, use only odd indices (two-phase-on patterns).
REQ-012 SHALL, on a tick, advance idx by ±1 in half step, and by ±2 in full step.
REQ-013 SHALL, on a full-step tick with an even idx, advance by ±1 to reach an odd idx, then use ±2 on later ticks.
REQ-014 SHALL wrap idx modulo 8 in both directions: 7+1 -> 0 and 0-1 -> 7.
REQ-015 SHALL count ticks with a 16-bit prescaler while run=1: clear it on the run rising edge, and assert the tick when it reaches DIV-1, then clear it.
REQ-016 SHALL put the first tick DIV cycles after the cycle in which run was first sampled high.
REQ-017 SHALL drive coils = table[idx] one cycle after run is sampled high, and update coils the cycle after each tick.
REQ-018 SHALL sample step and dir only on tick cycles; a mode or direction change takes effect at the next tick.
REQ-019 SHALL clear step_cnt on the run rising edge, increment it on each tick, and saturate it at 255.
REQ-020 SHALL, on run falling, stop stepping immediately with no further idx change; a tick coincident with run=0 SHALL be discarded.
REQ-021 SHALL drive busy = registered run, deasserting one cycle after run falls.
REQ-022 SHALL keep step_cnt at its final value after run falls, until the next run rising edge.

Reset
REQ-023 SHALL, while rst=0, set idx=0, prescaler=0, coils=0000, busy=0 and step_cnt=0.
REQ-024 SHALL let reset override run and tick in the same cycle; reset mid-run aborts the run with no tick.
REQ-025 SHALL treat run=1 at rst release as a rising edge on the first cycle after release.

Configuration
REQ-026 SHALL support macro STEP_HOLD_EN: when defined, coils hold table[idx] while run=0 after the first run (holding torque).
REQ-027 SHALL, when STEP_HOLD_EN is undefined, drive coils=0000 one cycle after run falls (coils de-energized).
REQ-028 SHALL leave idx retained across runs in both builds.

Structure
REQ-029 SHALL keep the 8-entry phase table, the step-mode encodings and the 3-bit index width in shared package step_pkg.
REQ-030 SHALL place the prescaler in sub-module step_tick_gen (ports clk, rst, en, tick; parameter DIV).
REQ-031 SHALL use no other sub-modules; the index/table logic, counter and output registers stay in step_phase_seq.

Verification (DIV=4)
REQ-032 SHALL cover: rst low, then high with run=0 -> coils=0000, step_cnt=0, busy=0.
REQ-033 SHALL cover: half step, dir=1, run high 20 cycles -> ticks at cycles 4, 8, 12, 16, 20; coils 1000 -> 1100 -> 0100 -> 0110 -> 0010 -> 0011; step_cnt=5.
REQ-034 SHALL cover: full step, dir=0, start idx=0 -> idx sequence 7, 5, 3, 1, 7; coils 1001, 0011, 0110, 1100, 1001.
REQ-035 SHALL cover: run falls on a tick cycle -> no idx change; coils=0000 without STEP_HOLD_EN, unchanged with it.
REQ-036 SHALL cover: run held for 1100 ticks -> step_cnt stays 255 and idx keeps wrapping.
REQ-037 SHALL cover: rst low for one cycle mid-run at step_cnt=3 -> next cycle idx=0, coils=0000, step_cnt=0; stepping restarts DIV cycles after release.
